// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// State encoding, byte-per-word geometry and RAM write-enable patterns.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_CHK,
    S_DONE
  } state_t;

  localparam int         BYTES_PER_WORD = 4;
  localparam logic [3:0] WEA_ALL        = 4'hF;
  localparam logic [3:0] WEA_NONE       = 4'h0;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Little-endian byte-to-word packer for the program loader.
// Bytes shift in from the top so the first byte lands in [7:0].
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  data,
  output logic [31:0] word_next,
  output logic        word_full
);

  logic [1:0]  idx;
  logic [31:0] word;

  assign word_next = {data, word[31:8]};
  assign word_full = push && (idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      word <= '0;
    end else if (clear) begin
      idx  <= '0;
      word <= '0;
    end else if (push) begin
      idx  <= idx + 2'd1;
      word <= word_next;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: streams bytes into the instruction/data RAM write port.
// Optional checksum byte check enabled by PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import loader_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                LEN_W     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic [3:0]        mem_wea_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_din_o,
  output logic              cpu_hold_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CHK;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t             state;
  state_t             next;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   wcnt;
  logic [LEN_W:0]     wcnt_inc;
  logic               acc;
  logic               push;
  logic               go;
  logic               word_full;
  logic [31:0]        word_next;

  assign acc      = byte_valid_i && byte_ready_o;
  assign push     = acc && (state == S_RECV);
  assign go       = (state == S_IDLE) && start_i;
  // One extra bit so len = 2^LEN_W-1 compares without wrap.
  assign wcnt_inc = {1'b0, wcnt} + (LEN_W+1)'(1);

  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (go),
    .push      (push),
    .data      (byte_i),
    .word_next (word_next),
    .word_full (word_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      S_IDLE: begin
        if (start_i) next = (len_i != '0) ? S_RECV : S_END;
      end
      S_RECV: begin
        if (word_full) next = S_WRITE;
      end
      S_WRITE: begin
        next = (wcnt_inc == {1'b0, len_q}) ? S_END : S_RECV;
      end
      S_CHK: begin
        if (acc) next = S_DONE;
      end
      S_DONE:  next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_ready_o <= 1'b0;
      mem_wea_o    <= WEA_NONE;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      byte_ready_o <= (next == S_RECV) || (next == S_CHK);
      mem_wea_o    <= (next == S_WRITE) ? WEA_ALL : WEA_NONE;
      busy_o       <= (next != S_IDLE);
      done_o       <= (next == S_DONE);
    end
  end

  assign cpu_hold_o = busy_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      wcnt       <= '0;
      mem_addr_o <= BASE_ADDR;
      mem_din_o  <= '0;
    end else begin
      if (go) begin
        len_q      <= len_i;
        wcnt       <= '0;
        mem_addr_o <= BASE_ADDR;
      end
      if (word_full) mem_din_o <= word_next;
      if (state == S_WRITE) begin
        mem_addr_o <= mem_addr_o + ADDR_W'(1);
        wcnt       <= wcnt + LEN_W'(1);
      end
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum  <= '0;
      err_q <= 1'b0;
    end else begin
      if (go) begin
        csum  <= '0;
        err_q <= 1'b0;
      end
      if (push) csum <= csum ^ byte_i;
      if (acc && (state == S_CHK) && (byte_i != csum)) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
// Two instances share stimulus: BASE_ADDR 0 and BASE_ADDR 16.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic [7:0]  byte_d = '0;
  logic        byte_valid = 1'b0;

  logic        ready, hold, busy, done, err;
  logic [3:0]  wea;
  logic [31:0] addr, din;
  logic        ready16, hold16, busy16, done16, err16;
  logic [3:0]  wea16;
  logic [31:0] addr16, din16;

  int errors = 0;
  int checks = 0;

  int nw = 0, nd = 0, nw16 = 0;
  logic [31:0] wa[$], wd[$], wa16[$], wd16[$];
  logic        wr[$];

  always #5 clk = ~clk;

  prog_loader dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .len_i(len),
    .byte_i(byte_d), .byte_valid_i(byte_valid), .byte_ready_o(ready),
    .mem_wea_o(wea), .mem_addr_o(addr), .mem_din_o(din),
    .cpu_hold_o(hold), .busy_o(busy), .done_o(done), .err_o(err)
  );

  prog_loader #(.BASE_ADDR(32'd16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .len_i(len),
    .byte_i(byte_d), .byte_valid_i(byte_valid), .byte_ready_o(ready16),
    .mem_wea_o(wea16), .mem_addr_o(addr16), .mem_din_o(din16),
    .cpu_hold_o(hold16), .busy_o(busy16), .done_o(done16), .err_o(err16)
  );

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (wea == 4'hF) begin
        wa.push_back(addr);
        wd.push_back(din);
        wr.push_back(ready);
        nw++;
      end
      if (done) nd++;
      if (wea16 == 4'hF) begin
        wa16.push_back(addr16);
        wd16.push_back(din16);
        nw16++;
      end
    end
  end

  task automatic pulse_start(input logic [15:0] l);
    start = 1'b1;
    len = l;
    @(posedge clk); #1;
    start = 1'b0;
    len = 16'hFFFF;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    byte_valid = 1'b1;
    byte_d = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = ready;
      @(posedge clk);
    end
    #1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_byte: byte %h not accepted within 50 cycles", b);
    end
  endtask

  task automatic gap(input int n);
    byte_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) begin
      if (gaps && $urandom_range(0, 1) == 1) gap($urandom_range(1, 3));
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 40 && nd == d0; i++) @(negedge clk);
    checks++;
    if (nd == d0) begin
      errors++;
      $display("FAIL wait_done: no done_o within 40 cycles");
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", ready); end
    checks++; if (wea !== 4'h0) begin errors++; $display("FAIL rst_wea: got %h want 0", wea); end
    checks++; if (addr !== 32'd0) begin errors++; $display("FAIL rst_addr: got %h want 0", addr); end
    checks++; if (addr16 !== 32'd16) begin errors++; $display("FAIL rst_addr16: got %h want 10", addr16); end
    checks++; if (din !== 32'd0) begin errors++; $display("FAIL rst_din: got %h want 0", din); end
    checks++; if ({hold, busy, done, err} !== 4'b0) begin errors++; $display("FAIL rst_flags: got %b want 0000", {hold, busy, done, err}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    int b;
    b = nw;
    pulse_start(16'd1);
    send_word(32'h12345678, 1'b0);
    byte_valid = 1'b0;
    @(negedge clk);
    checks++; if (wea !== 4'hF) begin errors++; $display("FAIL single_wea: got %h want f", wea); end
    checks++; if (addr !== 32'd0) begin errors++; $display("FAIL single_addr: got %h want 0", addr); end
    checks++; if (din !== 32'h12345678) begin errors++; $display("FAIL single_din: got %h want 12345678", din); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL single_ready_wr: got %b want 0", ready); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done: got %b want 1", done); end
    checks++; if (wea !== 4'h0) begin errors++; $display("FAIL single_wea_off: got %h want 0", wea); end
    checks++; if (addr !== 32'd1) begin errors++; $display("FAIL single_addr_inc: got %h want 1", addr); end
    @(negedge clk);
    checks++; if ({hold, busy, done} !== 3'b000) begin errors++; $display("FAIL single_idle: got %b want 000", {hold, busy, done}); end
    checks++; if (din !== 32'h12345678) begin errors++; $display("FAIL single_din_hold: got %h want 12345678", din); end
    checks++; if (nw - b !== 1) begin errors++; $display("FAIL single_nwrites: got %0d want 1", nw - b); end
    @(posedge clk); #1;
  endtask

  task automatic test_three_gaps;
    logic [31:0] words [3];
    int b, b16, d;
    words[0] = 32'hA1B2C3D4;
    words[1] = 32'h00FF7F80;
    words[2] = 32'hDEADBEEF;
    b = nw; b16 = nw16; d = nd;
    pulse_start(16'd3);
    for (int w = 0; w < 3; w++) send_word(words[w], 1'b1);
    byte_valid = 1'b0;
    wait_done(d);
    repeat (3) @(negedge clk);
    checks++; if (nw16 - b16 !== 3) begin errors++; $display("FAIL three_nwrites: got %0d want 3", nw16 - b16); end
    checks++; if (nd - d !== 1) begin errors++; $display("FAIL three_ndone: got %0d want 1", nd - d); end
    if (nw16 - b16 == 3 && nw - b == 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wa16[b16+i] !== 32'(16 + i)) begin
          errors++; $display("FAIL three_addr%0d: got %0d want %0d", i, wa16[b16+i], 16 + i);
        end
        checks++;
        if (wd16[b16+i] !== words[i] || wd[b+i] !== words[i]) begin
          errors++; $display("FAIL three_data%0d: got %h/%h want %h", i, wd16[b16+i], wd[b+i], words[i]);
        end
        checks++;
        if (wr[b+i] !== 1'b0) begin
          errors++; $display("FAIL three_ready%0d: got %b want 0", i, wr[b+i]);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero;
    int b, d;
    b = nw; d = nd;
    pulse_start(16'd0);
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL zero_ready: got %b want 0", ready); end
    repeat (3) @(negedge clk);
    checks++; if (nw !== b) begin errors++; $display("FAIL zero_nwrites: got %0d want 0", nw - b); end
    checks++; if (nd - d !== 1) begin errors++; $display("FAIL zero_ndone: got %0d want 1", nd - d); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_during;
    int b, d;
    b = nw; d = nd;
    pulse_start(16'd2);
    send_byte(8'h01);
    send_byte(8'h02);
    byte_valid = 1'b0;
    pulse_start(16'd5);
    for (int i = 3; i <= 8; i++) send_byte(8'(i));
    byte_valid = 1'b0;
    wait_done(d);
    repeat (12) @(negedge clk);
    checks++; if (nw - b !== 2) begin errors++; $display("FAIL during_nwrites: got %0d want 2", nw - b); end
    checks++; if (nd - d !== 1) begin errors++; $display("FAIL during_ndone: got %0d want 1", nd - d); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL during_busy: got %b want 0", busy); end
    if (nw - b == 2) begin
      checks++;
      if (wd[b] !== 32'h04030201 || wd[b+1] !== 32'h08070605) begin
        errors++; $display("FAIL during_data: got %h %h want 04030201 08070605", wd[b], wd[b+1]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int b;
    pulse_start(16'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    byte_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ready, hold, busy, done, err} !== 5'b0) begin errors++; $display("FAIL mid_flags: got %b want 00000", {ready, hold, busy, done, err}); end
    checks++; if (din !== 32'd0) begin errors++; $display("FAIL mid_din: got %h want 0", din); end
    checks++; if (addr16 !== 32'd16) begin errors++; $display("FAIL mid_addr16: got %h want 10", addr16); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    b = nw;
    pulse_start(16'd1);
    send_word(32'hAABBCCDD, 1'b0);
    byte_valid = 1'b0;
    @(negedge clk);
    checks++; if (wea !== 4'hF || addr !== 32'd0) begin errors++; $display("FAIL mid_write: got wea=%h addr=%h want f 0", wea, addr); end
    checks++; if (din !== 32'hAABBCCDD) begin errors++; $display("FAIL mid_din_new: got %h want aabbccdd", din); end
    checks++; if (addr16 !== 32'd16) begin errors++; $display("FAIL mid_addr16_new: got %h want 10", addr16); end
    repeat (3) @(negedge clk);
    checks++; if (nw - b !== 1) begin errors++; $display("FAIL mid_nwrites: got %0d want 1", nw - b); end
    @(posedge clk); #1;
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    pulse_start(16'd1);
    send_word(32'h12345678, 1'b0);
    send_byte(8'h08);
    byte_valid = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL chk_good: got done=%b err=%b want 1 0", done, err); end
    @(posedge clk); #1;
    pulse_start(16'd1);
    send_word(32'h12345678, 1'b0);
    send_byte(8'h09);
    byte_valid = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL chk_bad: got done=%b err=%b want 1 1", done, err); end
    repeat (2) @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL chk_sticky: got %b want 1", err); end
    @(posedge clk); #1;
    pulse_start(16'd1);
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL chk_clear: got %b want 0", err); end
    @(posedge clk); #1;
    send_word(32'h12345678, 1'b0);
    send_byte(8'h08);
    byte_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`else
    test_single();
    test_three_gaps();
    test_zero();
    test_start_during();
    test_reset_mid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
